// File: rtl/dark_channel_prep.sv
// Dark-channel front end: dark = min(R,G,B), emits A - dark and A, tracks A per frame.
// Optional HMIN3_EN: windowed 3-tap horizontal min of dark on the output path.
module dark_channel_prep #(
  parameter int PIX_W  = 8,
  parameter int A_INIT = 200,
  parameter int A_MIN  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  input  logic             in_sof,
  input  logic             in_sol,
  input  logic             in_eof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_dark_diff,
  output logic [PIX_W-1:0] out_denominator,
  output logic             out_eof,
  output logic [PIX_W-1:0] a_cur,
  output logic             frame_err
);

  localparam logic [PIX_W-1:0] A_INIT_V = PIX_W'(A_INIT);
  localparam logic [PIX_W-1:0] A_MIN_V  = PIX_W'(A_MIN);

  typedef enum logic [1:0] {IDLE, ACTIVE, UPDATE} state_t;

  state_t           state_reg, state_next;
  logic [PIX_W-1:0] frame_max_reg, frame_max_next;
  logic [PIX_W-1:0] a_cur_reg, a_cur_next;
  logic             frame_err_reg, frame_err_next;

  logic             advance;
  logic             accept;
  logic [PIX_W-1:0] rg_min;
  logic [PIX_W-1:0] pix_dark;
  logic [PIX_W-1:0] win_dark;

  logic             s1_valid_reg;
  logic [PIX_W-1:0] s1_dark_reg;
  logic [PIX_W-1:0] s1_a_reg;
  logic             s1_eof_reg;

  logic             out_valid_reg;
  logic [PIX_W-1:0] out_dark_diff_reg;
  logic [PIX_W-1:0] out_denominator_reg;
  logic             out_eof_reg;

  // Whole pipeline moves together; it only stalls when the output word is stuck.
  assign advance  = !out_valid_reg || out_ready;
  assign in_ready = rst_n && advance && (state_reg != UPDATE);
  assign accept   = in_valid && in_ready;

  assign rg_min   = (in_r < in_g) ? in_r : in_g;
  assign pix_dark = (rg_min < in_b) ? rg_min : in_b;

`ifdef HMIN3_EN
  logic [PIX_W-1:0] h1_reg, h2_reg;
  logic             h1_vld_reg, h2_vld_reg;

  // History taps only count inside the current line; in_sol starts a fresh window.
  always_comb begin
    win_dark = pix_dark;
    if (!in_sol) begin
      if (h1_vld_reg && (h1_reg < win_dark)) win_dark = h1_reg;
      if (h2_vld_reg && (h2_reg < win_dark)) win_dark = h2_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_reg     <= '0;
      h2_reg     <= '0;
      h1_vld_reg <= 1'b0;
      h2_vld_reg <= 1'b0;
    end else if (accept) begin
      h1_reg     <= pix_dark;
      h1_vld_reg <= 1'b1;
      h2_reg     <= h1_reg;
      h2_vld_reg <= in_sol ? 1'b0 : h1_vld_reg;
    end
  end
`else
  logic unused_sol;
  assign unused_sol = in_sol;
  assign win_dark   = pix_dark;
`endif

  // Frame tracking uses the unwindowed per-pixel dark.
  always_comb begin
    state_next     = state_reg;
    frame_max_next = frame_max_reg;
    a_cur_next     = a_cur_reg;
    frame_err_next = frame_err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (in_sof) begin
            frame_max_next = pix_dark;
            state_next     = in_eof ? UPDATE : ACTIVE;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (accept) begin
          if (in_sof) begin
            frame_max_next = pix_dark;
            frame_err_next = 1'b1;
          end else if (pix_dark > frame_max_reg) begin
            frame_max_next = pix_dark;
          end
          if (in_eof) state_next = UPDATE;
        end
      end
      UPDATE: begin
        a_cur_next = (frame_max_reg > A_MIN_V) ? frame_max_reg : A_MIN_V;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      frame_max_reg <= '0;
      a_cur_reg     <= A_INIT_V;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_max_reg <= frame_max_next;
      a_cur_reg     <= a_cur_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // A is captured with the pixel so a later update cannot touch words in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_dark_reg  <= '0;
      s1_a_reg     <= '0;
      s1_eof_reg   <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_dark_reg <= win_dark;
        s1_a_reg    <= a_cur_reg;
        s1_eof_reg  <= in_eof;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg       <= 1'b0;
      out_dark_diff_reg   <= '0;
      out_denominator_reg <= '0;
      out_eof_reg         <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_dark_diff_reg   <= (s1_dark_reg >= s1_a_reg) ? '0 : (s1_a_reg - s1_dark_reg);
        out_denominator_reg <= s1_a_reg;
        out_eof_reg         <= s1_eof_reg;
      end
    end
  end

  assign out_valid       = out_valid_reg;
  assign out_dark_diff   = out_dark_diff_reg;
  assign out_denominator = out_denominator_reg;
  assign out_eof         = out_eof_reg;
  assign a_cur           = a_cur_reg;
  assign frame_err       = frame_err_reg;

endmodule

// File: tb/tb_dark_channel_prep.sv
// Bench for dark_channel_prep: transaction-level model plus scoreboard, with literal pins.
module tb_dark_channel_prep;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_r, in_g, in_b;
  logic       in_sof, in_sol, in_eof;
  logic       out_valid, out_ready;
  logic [7:0] out_dark_diff, out_denominator, a_cur;
  logic       out_eof, frame_err;

  dark_channel_prep dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_sof(in_sof), .in_sol(in_sol), .in_eof(in_eof),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dark_diff(out_dark_diff), .out_denominator(out_denominator), .out_eof(out_eof),
    .a_cur(a_cur), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  exp_diff_q[$];
  int  exp_den_q[$];
  int  exp_eof_q[$];
  int  log_diff[$];
  int  log_den[$];
  int  line_hist[$];
  int  a_model, a_pend, fmax_model, upd_cnt;
  bit  in_frame, err_model;
  bit  hold_flag;
  int  hold_diff, hold_den, hold_eof;

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_diff_q.delete(); exp_den_q.delete(); exp_eof_q.delete();
      line_hist.delete();
      a_model = 200; a_pend = 200; fmax_model = 0; upd_cnt = 0;
      in_frame = 0; err_model = 0; hold_flag = 0;
    end else begin
      if (upd_cnt > 0) begin
        upd_cnt--;
        if (upd_cnt == 0) a_model = a_pend;
      end
      chk("a_cur", int'(a_cur), a_model);
      chk("frame_err", int'(frame_err), int'(err_model));
      chk("in_ready", int'(in_ready), int'((!out_valid || out_ready) && (upd_cnt != 1)));

      if (hold_flag) begin
        chk("hold_diff", int'(out_dark_diff), hold_diff);
        chk("hold_den", int'(out_denominator), hold_den);
        chk("hold_eof", int'(out_eof), hold_eof);
        hold_flag = 0;
      end

      if (out_valid) begin
        if (out_ready) begin
          if (exp_diff_q.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            chk("out_dark_diff", int'(out_dark_diff), exp_diff_q.pop_front());
            chk("out_denominator", int'(out_denominator), exp_den_q.pop_front());
            chk("out_eof", int'(out_eof), exp_eof_q.pop_front());
            log_diff.push_back(int'(out_dark_diff));
            log_den.push_back(int'(out_denominator));
          end
        end else begin
          hold_flag = 1;
          hold_diff = int'(out_dark_diff);
          hold_den  = int'(out_denominator);
          hold_eof  = int'(out_eof);
        end
      end

      if (in_valid && in_ready) begin
        int d, wd, n;
        d = min3(int'(in_r), int'(in_g), int'(in_b));
        if (in_sol) line_hist.delete();
        line_hist.push_back(d);
        wd = d;
`ifdef HMIN3_EN
        n = line_hist.size();
        for (int i = (n > 3 ? n - 3 : 0); i < n; i++)
          if (line_hist[i] < wd) wd = line_hist[i];
`else
        n = 0;
`endif
        exp_diff_q.push_back((wd >= a_model) ? 0 : a_model - wd);
        exp_den_q.push_back(a_model);
        exp_eof_q.push_back(int'(in_eof));
        if (in_sof) begin
          if (in_frame) err_model = 1;
          fmax_model = d;
          in_frame = 1;
        end else if (!in_frame) begin
          err_model = 1;
        end else if (d > fmax_model) begin
          fmax_model = d;
        end
        if (in_eof && in_frame) begin
          in_frame = 0;
          a_pend = (fmax_model > 16) ? fmax_model : 16;
          upd_cnt = 2;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int r, input int g, input int b,
                      input bit sof, input bit sol, input bit eof);
    int n;
    in_valid = 1'b1;
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
    in_sof = sof; in_sol = sol; in_eof = eof;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
    in_sof = 1'b0; in_sol = 1'b0; in_eof = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_diff_q.size() != 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_timeout", int'(exp_diff_q.size() != 0), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  int base;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_r = '0; in_g = '0; in_b = '0; in_sof = 0; in_sol = 0; in_eof = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_a_cur", int'(a_cur), 200);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_diff", int'(out_dark_diff), 0);
    chk("rst_den", int'(out_denominator), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // single-pixel frame
    base = log_diff.size();
    send(90, 40, 120, 1, 1, 1);
    drain();
    chk("t1_diff", log_diff[base], 160);
    chk("t1_den", log_den[base], 200);
    chk("t1_a_cur", int'(a_cur), 40);

    // darks 10,250,30,5 under A=40
    base = log_diff.size();
    send(10, 20, 30, 1, 1, 0);
    send(250, 250, 255, 0, 0, 0);
    send(30, 99, 40, 0, 0, 0);
    send(5, 5, 5, 0, 0, 1);
    drain();
    chk("t2_diff0", log_diff[base], 30);
    chk("t2_diff1_clamp", log_diff[base+1], 0);
    chk("t2_a_cur", int'(a_cur), 250);

    // dark 5 under A=250, frame max 5 floors to A_MIN
    base = log_diff.size();
    send(7, 5, 9, 1, 1, 0);
    send(5, 6, 8, 0, 0, 1);
    drain();
    chk("t3_diff", log_diff[base], 245);
    chk("t3_den", log_den[base], 250);
    chk("t3_a_floor", int'(a_cur), 16);

    // all darks 3, then a dark-20 pixel clamps against A=16
    send(3, 4, 5, 1, 1, 0);
    send(3, 3, 3, 0, 0, 0);
    send(9, 3, 6, 0, 0, 1);
    drain();
    chk("t4_a_min", int'(a_cur), 16);
    base = log_diff.size();
    send(20, 30, 40, 1, 1, 0);
    send(100, 150, 200, 0, 0, 1);
    drain();
    chk("t4_clamp_diff", log_diff[base], 0);
    chk("t4_clamp_den", log_den[base], 16);
    chk("t4_a_cur", int'(a_cur), 100);

    // stall: out_ready low for 5 cycles with a continuous stream
    base = log_diff.size();
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(15*(k+1), 200, 200, k == 0, k == 0, k == 7);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", int'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", log_diff.size() - base, 8);
    chk("stall_first", log_diff[base], 85);
    chk("stall_last", log_diff[base+7], 0);
    chk("stall_a_cur", int'(a_cur), 120);

    // line windowing: darks 50,20,70,90 then a new line with 80, A=120
    base = log_diff.size();
    send(50, 60, 70, 1, 1, 0);
    send(20, 90, 90, 0, 0, 0);
    send(70, 80, 90, 0, 0, 0);
    send(90, 95, 99, 0, 0, 0);
    send(80, 85, 88, 0, 1, 1);
    drain();
    chk("win0", log_diff[base], 70);
    chk("win1", log_diff[base+1], 100);
`ifdef HMIN3_EN
    chk("win2", log_diff[base+2], 100);
    chk("win3", log_diff[base+3], 100);
`else
    chk("win2", log_diff[base+2], 50);
    chk("win3", log_diff[base+3], 30);
`endif
    chk("win4_newline", log_diff[base+4], 40);
    chk("win_a_cur", int'(a_cur), 90);

    // pixels without sof in IDLE
    base = log_diff.size();
    send(50, 60, 70, 0, 1, 0);
    drain();
    chk("err_set", int'(frame_err), 1);
    chk("err_a_same", int'(a_cur), 90);
    send(60, 70, 80, 0, 0, 1);
    drain();
    chk("err_sticky", int'(frame_err), 1);
    chk("err_a_still", int'(a_cur), 90);
    chk("err_diff", log_diff[base], 40);

    // reset in the middle of a frame
    send(10, 10, 10, 1, 1, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_a_cur", int'(a_cur), 200);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_err", int'(frame_err), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    base = log_diff.size();
    send(10, 20, 30, 1, 1, 1);
    drain();
    chk("post_rst_diff", log_diff[base], 190);
    chk("post_rst_a", int'(a_cur), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
